// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and sizing helper for the HUB75 panel receiver
package hub75_pkg;
  typedef logic [2:0] rgb_t;
  typedef enum logic {DARK, LIT} lit_state_t;
  function automatic int cnt_w_for(input int length);
    return $clog2(length + 2);
  endfunction
endpackage

// File: rtl/hub75_shift_chain.sv
// hub75_shift_chain: serial rgb shift chain with latched display register
module hub75_shift_chain
  import hub75_pkg::*;
#(
  parameter int length = 5
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  sclk_rise,
  input  rgb_t                  din,
  input  logic                  latch_rise,
  output logic [3*length-1:0]   disp
);
  logic [3*length-1:0] chain, chain_nx;
  always_comb chain_nx = sclk_rise ? {chain[3*length-4:0], din} : chain;
  always_ff @(posedge clk)
    if (!reset_b) begin
      chain <= '0;
      disp  <= '0;
    end else begin
      chain <= chain_nx;
      if (latch_rise) disp <= chain_nx;
    end
endmodule

// File: rtl/hub75_panel_rx.sv
// hub75_panel_rx: decodes HUB75 scanner signals into lit rows, pixel words and lit time
module hub75_panel_rx
  import hub75_pkg::*;
#(
  parameter int length   = 5,
  parameter int scan_bit = 2,
  parameter int cnt_w    = 16
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [2:0]          rgb1,
  input  logic [2:0]          rgb2,
  input  logic                sclk,
  input  logic                latch,
  input  logic                oe_b,
  input  logic [scan_bit-1:0] select,
  output logic                lit_valid,
  output logic [scan_bit-1:0] lit_row,
  output logic [3*length-1:0] lit_data1,
  output logic [3*length-1:0] lit_data2,
  output logic [cnt_w-1:0]    lit_cycles,
  output logic                err_count,
  output logic                err_select
);
  localparam int sc_w = cnt_w_for(length);
  localparam logic [sc_w-1:0] sc_max = sc_w'(length + 1);
  localparam logic [sc_w-1:0] sc_len = sc_w'(length);
  rgb_t                rgb1_s, rgb2_s;
  logic                sclk_s, latch_s, oe_b_s, sclk_p, latch_p;
  logic                sclk_rise, latch_rise;
  logic [scan_bit-1:0] select_s, row_q;
  logic [sc_w-1:0]     shift_cnt, cnt_nx;
  logic [cnt_w-1:0]    cyc;
  lit_state_t          state, state_nx;
  always_ff @(posedge clk)
    if (!reset_b) begin
      rgb1_s   <= '0;
      rgb2_s   <= '0;
      sclk_s   <= 1'b0;
      latch_s  <= 1'b0;
      oe_b_s   <= 1'b1;
      select_s <= '0;
      sclk_p   <= 1'b0;
      latch_p  <= 1'b0;
    end else begin
      rgb1_s   <= rgb1;
      rgb2_s   <= rgb2;
      sclk_s   <= sclk;
      latch_s  <= latch;
      oe_b_s   <= oe_b;
      select_s <= select;
      sclk_p   <= sclk_s;
      latch_p  <= latch_s;
    end
  always_comb begin
    sclk_rise  = sclk_s & ~sclk_p;
    latch_rise = latch_s & ~latch_p;
    cnt_nx     = (sclk_rise && shift_cnt != sc_max) ? shift_cnt + 1'b1 : shift_cnt;
    state_nx   = oe_b_s ? DARK : LIT;
  end
  always_ff @(posedge clk)
    if (!reset_b) begin
      state      <= DARK;
      shift_cnt  <= '0;
      row_q      <= '0;
      cyc        <= '0;
      lit_valid  <= 1'b0;
      lit_row    <= '0;
      lit_cycles <= '0;
      err_count  <= 1'b0;
      err_select <= 1'b0;
    end else begin
      state     <= state_nx;
      lit_valid <= 1'b0;
      shift_cnt <= latch_rise ? '0 : cnt_nx;
      if (latch_rise && cnt_nx != sc_len) err_count <= 1'b1;
      if (state == DARK && !oe_b_s) begin
        row_q <= select_s;
        cyc   <= cnt_w'(1);
      end
      if (state == LIT && oe_b_s) begin
        lit_valid  <= 1'b1;
        lit_row    <= row_q;
        lit_cycles <= cyc;
      end
      if (state == LIT && !oe_b_s) begin
        cyc <= cyc + cnt_w'(cyc != '1);
        if (select_s != row_q) err_select <= 1'b1;
      end
    end
  hub75_shift_chain #(.length(length)) u_chain1 (
    .clk(clk), .reset_b(reset_b), .sclk_rise(sclk_rise), .din(rgb1_s),
    .latch_rise(latch_rise), .disp(lit_data1)
  );
  hub75_shift_chain #(.length(length)) u_chain2 (
    .clk(clk), .reset_b(reset_b), .sclk_rise(sclk_rise), .din(rgb2_s),
    .latch_rise(latch_rise), .disp(lit_data2)
  );
endmodule

// File: tb/tb_hub75_panel_rx.sv
// tb_hub75_panel_rx: directed scoreboard bench for the HUB75 panel receiver
module tb_hub75_panel_rx;
  logic        clk = 1'b0;
  logic        reset_b;
  logic [2:0]  rgb1, rgb2;
  logic        sclk, latch, oe_b;
  logic [1:0]  select;
  logic        lit_valid;
  logic [1:0]  lit_row;
  logic [14:0] lit_data1, lit_data2;
  logic [15:0] lit_cycles;
  logic        err_count, err_select;
  int          errors = 0;
  int          checks = 0;
  typedef struct packed {
    logic [1:0]  row;
    logic [15:0] cyc;
    logic [14:0] d1;
    logic [14:0] d2;
  } exp_t;
  exp_t        q[$];
  logic [14:0] m1 = '0, m2 = '0, md1 = '0, md2 = '0;
  hub75_panel_rx #(.length(5), .scan_bit(2), .cnt_w(16)) dut (
    .clk(clk), .reset_b(reset_b), .rgb1(rgb1), .rgb2(rgb2), .sclk(sclk),
    .latch(latch), .oe_b(oe_b), .select(select), .lit_valid(lit_valid),
    .lit_row(lit_row), .lit_data1(lit_data1), .lit_data2(lit_data2),
    .lit_cycles(lit_cycles), .err_count(err_count), .err_select(err_select)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic shift(input logic [2:0] a, input logic [2:0] b, input logic with_latch = 1'b0);
    rgb1 = a;
    rgb2 = b;
    sclk = 1'b1;
    latch = with_latch;
    m1 = {m1[11:0], a};
    m2 = {m2[11:0], b};
    if (with_latch) begin
      md1 = m1;
      md2 = m2;
    end
    step();
    sclk = 1'b0;
    latch = 1'b0;
    step();
  endtask
  task automatic do_latch();
    latch = 1'b1;
    md1 = m1;
    md2 = m2;
    step();
    latch = 1'b0;
    step();
  endtask
  task automatic lit(input logic [1:0] sel, input int n, input int chg = -1, input logic [1:0] sel2 = 2'd0);
    q.push_back('{row: sel, cyc: 16'(n), d1: md1, d2: md2});
    select = sel;
    oe_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == chg) select = sel2;
      step();
    end
    oe_b = 1'b1;
    step(4);
  endtask
  always @(negedge clk)
    if (lit_valid) begin
      if (q.size() == 0) chk("spurious_lit_valid", 32'(lit_valid), 32'(0));
      else begin
        exp_t e;
        e = q.pop_front();
        chk("lit_row", 32'(lit_row), 32'(e.row));
        chk("lit_cycles", 32'(lit_cycles), 32'(e.cyc));
        chk("lit_data1", 32'(lit_data1), 32'(e.d1));
        chk("lit_data2", 32'(lit_data2), 32'(e.d2));
      end
    end
  initial begin
    reset_b = 1'b0;
    rgb1 = '0;
    rgb2 = '0;
    sclk = 1'b0;
    latch = 1'b0;
    oe_b = 1'b1;
    select = '0;
    step(3);
    chk("rst_lit_valid", 32'(lit_valid), 32'(0));
    chk("rst_lit_data1", 32'(lit_data1), 32'(0));
    chk("rst_lit_cycles", 32'(lit_cycles), 32'(0));
    chk("rst_errs", 32'({err_count, err_select}), 32'(0));
    reset_b = 1'b1;
    step(2);
    for (int i = 1; i <= 5; i++) shift(3'(i), 3'(~i));
    do_latch();
    step();
    chk("t1_disp1", 32'(lit_data1), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5}));
    chk("t1_disp2", 32'(lit_data2), 32'(~{3'd1, 3'd2, 3'd3, 3'd4, 3'd5} & 15'h7fff));
    lit(2'd2, 8);
    chk("t1_err_count", 32'(err_count), 32'(0));
    chk("t1_err_select", 32'(err_select), 32'(0));
    lit(2'd0, 1);
    for (int i = 6; i <= 9; i++) shift(3'(i), 3'(~i));
    shift(3'd2, 3'd5, 1'b1);
    step(2);
    chk("t4_err_count", 32'(err_count), 32'(0));
    lit(2'd1, 3);
    for (int i = 0; i < 4; i++) shift(3'(i + 3), 3'(i));
    do_latch();
    step();
    chk("t3_short_err", 32'(err_count), 32'(1));
    for (int i = 0; i < 6; i++) shift(3'(7 - i), 3'(i + 1));
    do_latch();
    step();
    chk("t3_long_err", 32'(err_count), 32'(1));
    lit(2'd3, 5);
    chk("t5_err_select_before", 32'(err_select), 32'(0));
    lit(2'd1, 6, 3, 2'd3);
    chk("t5_err_select", 32'(err_select), 32'(1));
    for (int i = 0; i < 3; i++) shift(3'(i + 1), 3'(i + 4));
    reset_b = 1'b0;
    step(2);
    chk("t6_err_count", 32'(err_count), 32'(0));
    chk("t6_err_select", 32'(err_select), 32'(0));
    chk("t6_data1", 32'(lit_data1), 32'(0));
    chk("t6_cycles", 32'(lit_cycles), 32'(0));
    m1 = '0;
    m2 = '0;
    md1 = '0;
    md2 = '0;
    reset_b = 1'b1;
    step(2);
    oe_b = 1'b0;
    step(3);
    reset_b = 1'b0;
    oe_b = 1'b1;
    step(2);
    chk("t6_lit_valid_in_reset", 32'(lit_valid), 32'(0));
    reset_b = 1'b1;
    step(4);
    for (int i = 0; i < 5; i++) shift(3'(7 - i), 3'(i + 2));
    do_latch();
    lit(2'd3, 4);
    chk("t6_post_errs", 32'({err_count, err_select}), 32'(0));
    step(5);
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
